tcp_rx_session_reader: RTL and testbench

- Native-RTL, parametrised successor to the HLS TCP RX handler path. Sits between the TCP offload engine and application logic on net_clk.
- Accepts TOE notifications and splits each into read_package requests of at most MAX_READ_BYTES.
- Tracks outstanding reads in a pending FIFO, matches returning rx_metadata/rx_data to them, and forwards data tagged with its session ID. Session and length mismatches are counted.

---
 rtl/tcp_handler_pkg.sv | 61 ++++++
 rtl/tcp_pending_fifo.sv | 68 ++++++
 rtl/tcp_rx_session_reader.sv | 244 ++++++++++++++++++++++++
 tb/tb_tcp_rx_session_reader.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_handler_pkg.sv
// -----------------------------------------------------------------------------
// tcp_handler_pkg
//   Shared types and widths for the TCP RX session reader.
//   - notification_t : TOE notification word (88 bits)
//                      [15:0] session, [31:16] length, [63:32] ip,
//                      [79:64] port, [80] closed, [87:81] reserved
//   - read_pkg_t     : read request word (32 bits)
//                      [15:0] session, [31:16] length
//   - pending_t      : one outstanding read kept in the pending FIFO
//   - req_state_t / rsp_state_t : request and response FSM states
//   - clip_len()     : min(remaining, max_len) for splitting notifications
// -----------------------------------------------------------------------------
package tcp_handler_pkg;

  localparam int SESSION_W  = 16;
  localparam int LEN_W      = 16;
  localparam int NOTIF_W    = 88;
  localparam int READ_PKG_W = SESSION_W + LEN_W;

  // Per-packet byte accumulator; one bit wider than a length so an
  // over-long packet still reads as a mismatch instead of wrapping.
  localparam int ACC_W = 17;

  typedef logic [SESSION_W-1:0] session_t;
  typedef logic [LEN_W-1:0]     len_t;

  // Packed structs list fields MSB first.
  typedef struct packed {
    logic [6:0]  rsvd;
    logic        closed;
    logic [15:0] port;
    logic [31:0] ip;
    len_t        length;
    session_t    session;
  } notification_t;

  typedef struct packed {
    len_t     length;
    session_t session;
  } read_pkg_t;

  typedef struct packed {
    session_t session;
    len_t     len;
  } pending_t;

  typedef enum logic {
    Q_IDLE,
    Q_ISSUE
  } req_state_t;

  typedef enum logic {
    R_META,
    R_DATA
  } rsp_state_t;

  function automatic len_t clip_len(input len_t remaining, input len_t max_len);
    return (remaining > max_len) ? max_len : remaining;
  endfunction

endpackage

// File: rtl/tcp_pending_fifo.sv
// -----------------------------------------------------------------------------
// tcp_pending_fifo
//   Synchronous FIFO of outstanding read requests (pending_t).
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     push, push_data : write request; ignored while full
//     pop             : remove head; ignored while empty
//     full, empty     : occupancy flags, decoded from the registered count
//     head            : oldest entry (valid while !empty)
//   DEPTH must be a power of two so the pointers wrap for free.
// -----------------------------------------------------------------------------
module tcp_pending_fifo
  import tcp_handler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  pending_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output pending_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pending_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Full is decoded from the count as it stood at the start of the cycle,
  // so a pop in the same cycle cannot make room for a push while full.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it was
  // written, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tcp_rx_session_reader.sv
// -----------------------------------------------------------------------------
// tcp_rx_session_reader
//   Splits TOE notifications into read_package requests of at most
//   MAX_READ_BYTES, remembers each outstanding read in a pending FIFO and
//   matches the returning rx_metadata / rx_data stream against it. Payload is
//   forwarded to the application tagged with its session; session and length
//   mismatches are counted and latch err_sticky.
//
//   Ports:
//     net_clk, net_aresetn          : clock, asynchronous active-low reset
//     s_axis_notif_*                : notification in (notification_t)
//     m_axis_read_pkg_*             : read request out (read_pkg_t)
//     s_axis_rx_meta_*              : session of the next rx payload
//     s_axis_rx_data_*              : rx payload beats
//     m_axis_app_*                  : payload to application + session tag
//     stat_*_cnt                    : statistics, CNT_W bits, wrapping
//     err_sticky                    : any mismatch since reset
// -----------------------------------------------------------------------------
module tcp_rx_session_reader
  import tcp_handler_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int MAX_READ_BYTES = 1536,
  parameter int PENDING_DEPTH  = 8,
  parameter int CNT_W          = 32
) (
  input  logic                    net_clk,
  input  logic                    net_aresetn,

  input  logic                    s_axis_notif_valid,
  output logic                    s_axis_notif_ready,
  input  logic [NOTIF_W-1:0]      s_axis_notif_data,

  output logic                    m_axis_read_pkg_valid,
  input  logic                    m_axis_read_pkg_ready,
  output logic [READ_PKG_W-1:0]   m_axis_read_pkg_data,

  input  logic                    s_axis_rx_meta_valid,
  output logic                    s_axis_rx_meta_ready,
  input  logic [SESSION_W-1:0]    s_axis_rx_meta_data,

  input  logic                    s_axis_rx_data_valid,
  output logic                    s_axis_rx_data_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_rx_data_data,
  input  logic [DATA_WIDTH/8-1:0] s_axis_rx_data_keep,
  input  logic                    s_axis_rx_data_last,

  output logic                    m_axis_app_valid,
  input  logic                    m_axis_app_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_app_data,
  output logic [DATA_WIDTH/8-1:0] m_axis_app_keep,
  output logic                    m_axis_app_last,
  output logic [SESSION_W-1:0]    m_axis_app_session,

  output logic [CNT_W-1:0]        stat_notif_cnt,
  output logic [CNT_W-1:0]        stat_req_cnt,
  output logic [CNT_W-1:0]        stat_byte_cnt,
  output logic [CNT_W-1:0]        stat_sess_err_cnt,
  output logic [CNT_W-1:0]        stat_len_err_cnt,
  output logic                    err_sticky
);

  localparam int   KEEP_W  = DATA_WIDTH / 8;
  localparam len_t MAX_LEN = len_t'(MAX_READ_BYTES);

  // ---------------------------------------------------------------------------
  // Pending FIFO
  // ---------------------------------------------------------------------------
  logic     fifo_push;
  pending_t fifo_push_data;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  pending_t fifo_head;

  tcp_pending_fifo #(
    .DEPTH (PENDING_DEPTH)
  ) u_pending_fifo (
    .clk       (net_clk),
    .rst_n     (net_aresetn),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // ---------------------------------------------------------------------------
  // Request side: notification -> read_package requests
  // ---------------------------------------------------------------------------
  req_state_t    q_state;
  session_t      req_session;
  len_t          remaining;
  len_t          req_len;
  notification_t notif;
  logic          notif_fire;
  logic          req_fire;
  len_t          rem_after;

  assign notif = notification_t'(s_axis_notif_data);

  // ip, port and closed carry nothing this block needs.
  logic unused_notif_bits;
  assign unused_notif_bits = ^{notif.rsvd, notif.closed, notif.ip, notif.port};

  assign s_axis_notif_ready = (q_state == Q_IDLE);
  assign notif_fire         = s_axis_notif_valid && s_axis_notif_ready;

  // Valid is gated by full; full can only rise through our own accepted push,
  // so a request that is already offered is never withdrawn.
  assign m_axis_read_pkg_valid = (q_state == Q_ISSUE) && !fifo_full;
  assign m_axis_read_pkg_data  = read_pkg_t'{length: req_len, session: req_session};
  assign req_fire              = m_axis_read_pkg_valid && m_axis_read_pkg_ready;
  assign rem_after             = remaining - req_len;

  assign fifo_push      = req_fire;
  assign fifo_push_data = pending_t'{session: req_session, len: req_len};

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      q_state        <= Q_IDLE;
      req_session    <= '0;
      remaining      <= '0;
      req_len        <= '0;
      stat_notif_cnt <= '0;
      stat_req_cnt   <= '0;
    end else begin
      case (q_state)
        Q_IDLE: begin
          if (notif_fire) begin
            stat_notif_cnt <= stat_notif_cnt + 1'b1;
            // Zero-length notifications are counted and dropped.
            if (notif.length != '0) begin
              req_session <= notif.session;
              remaining   <= notif.length;
              req_len     <= clip_len(notif.length, MAX_LEN);
              q_state     <= Q_ISSUE;
            end
          end
        end
        Q_ISSUE: begin
          // req_len only moves on acceptance, keeping data stable under stall.
          if (req_fire) begin
            stat_req_cnt <= stat_req_cnt + 1'b1;
            remaining    <= rem_after;
            req_len      <= clip_len(rem_after, MAX_LEN);
            if (rem_after == '0) q_state <= Q_IDLE;
          end
        end
        default: q_state <= Q_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response side: meta + payload matched against the pending FIFO head
  // ---------------------------------------------------------------------------
  rsp_state_t       r_state;
  session_t         app_session_r;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] beat_bytes;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             in_data;
  logic             meta_fire;
  logic             beat_fire;
  logic             sess_err_evt;
  logic             len_err_evt;

  // Meta is only taken when there is a read to match it against; the head
  // then stays put until this packet's last beat pops it.
  assign s_axis_rx_meta_ready = (r_state == R_META) && !fifo_empty;
  assign meta_fire            = s_axis_rx_meta_valid && s_axis_rx_meta_ready;

  // Zero-latency pass-through while in a packet.
  assign in_data              = (r_state == R_DATA);
  assign s_axis_rx_data_ready = in_data && m_axis_app_ready;
  assign m_axis_app_valid     = in_data && s_axis_rx_data_valid;
  assign m_axis_app_data      = s_axis_rx_data_data;
  assign m_axis_app_keep      = s_axis_rx_data_keep;
  assign m_axis_app_last      = s_axis_rx_data_last;
  assign m_axis_app_session   = app_session_r;
  assign beat_fire            = m_axis_app_valid && m_axis_app_ready;

  // NOTE: combinational logic assigns its output a default before anything
  // else and uses blocking (=) so the running sum is read back in order;
  // a path that skips the assignment would infer a latch.
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + ACC_W'(s_axis_rx_data_keep[i]);
    end
  end

  // Saturating accumulate including the current beat.
  assign acc_sum  = {1'b0, acc} + {1'b0, beat_bytes};
  assign acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

  assign fifo_pop     = beat_fire && s_axis_rx_data_last;
  assign sess_err_evt = meta_fire && (s_axis_rx_meta_data != fifo_head.session);
  assign len_err_evt  = fifo_pop && (acc_next != {1'b0, fifo_head.len});

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      r_state           <= R_META;
      app_session_r     <= '0;
      acc               <= '0;
      stat_byte_cnt     <= '0;
      stat_sess_err_cnt <= '0;
      stat_len_err_cnt  <= '0;
      err_sticky        <= 1'b0;
    end else begin
      case (r_state)
        R_META: begin
          if (meta_fire) begin
            // A session mismatch is recorded but the packet is still
            // forwarded under the session the meta word claims.
            app_session_r <= s_axis_rx_meta_data;
            acc           <= '0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (beat_fire) begin
            stat_byte_cnt <= stat_byte_cnt + CNT_W'(beat_bytes);
            if (s_axis_rx_data_last) begin
              acc     <= '0;
              r_state <= R_META;
            end else begin
              acc <= acc_next;
            end
          end
        end
        default: r_state <= R_META;
      endcase

      if (sess_err_evt) stat_sess_err_cnt <= stat_sess_err_cnt + 1'b1;
      if (len_err_evt)  stat_len_err_cnt  <= stat_len_err_cnt + 1'b1;
      if (sess_err_evt || len_err_evt) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcp_rx_session_reader.sv
// -----------------------------------------------------------------------------
// tb_tcp_rx_session_reader
//   Self-checking bench for tcp_rx_session_reader (default parameters).
//   The reference model splits notifications into expected requests with
//   plain arithmetic, keeps the outstanding reads in a queue and predicts
//   every app beat and every statistic. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tcp_rx_session_reader;
  import tcp_handler_pkg::*;

  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int MAXR  = 1536;
  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int LIMIT = 5000;

  logic           net_clk = 1'b0;
  logic           net_aresetn = 1'b0;
  logic           s_axis_notif_valid;
  logic           s_axis_notif_ready;
  logic [87:0]    s_axis_notif_data;
  logic           m_axis_read_pkg_valid;
  logic           m_axis_read_pkg_ready;
  logic [31:0]    m_axis_read_pkg_data;
  logic           s_axis_rx_meta_valid;
  logic           s_axis_rx_meta_ready;
  logic [15:0]    s_axis_rx_meta_data;
  logic           s_axis_rx_data_valid;
  logic           s_axis_rx_data_ready;
  logic [DW-1:0]  s_axis_rx_data_data;
  logic [KW-1:0]  s_axis_rx_data_keep;
  logic           s_axis_rx_data_last;
  logic           m_axis_app_valid;
  logic           m_axis_app_ready = 1'b1;
  logic [DW-1:0]  m_axis_app_data;
  logic [KW-1:0]  m_axis_app_keep;
  logic           m_axis_app_last;
  logic [15:0]    m_axis_app_session;
  logic [CW-1:0]  stat_notif_cnt, stat_req_cnt, stat_byte_cnt;
  logic [CW-1:0]  stat_sess_err_cnt, stat_len_err_cnt;
  logic           err_sticky;

  tcp_rx_session_reader #(
    .DATA_WIDTH     (DW),
    .MAX_READ_BYTES (MAXR),
    .PENDING_DEPTH  (DEPTH),
    .CNT_W          (CW)
  ) dut (
    .net_clk               (net_clk),
    .net_aresetn           (net_aresetn),
    .s_axis_notif_valid    (s_axis_notif_valid),
    .s_axis_notif_ready    (s_axis_notif_ready),
    .s_axis_notif_data     (s_axis_notif_data),
    .m_axis_read_pkg_valid (m_axis_read_pkg_valid),
    .m_axis_read_pkg_ready (m_axis_read_pkg_ready),
    .m_axis_read_pkg_data  (m_axis_read_pkg_data),
    .s_axis_rx_meta_valid  (s_axis_rx_meta_valid),
    .s_axis_rx_meta_ready  (s_axis_rx_meta_ready),
    .s_axis_rx_meta_data   (s_axis_rx_meta_data),
    .s_axis_rx_data_valid  (s_axis_rx_data_valid),
    .s_axis_rx_data_ready  (s_axis_rx_data_ready),
    .s_axis_rx_data_data   (s_axis_rx_data_data),
    .s_axis_rx_data_keep   (s_axis_rx_data_keep),
    .s_axis_rx_data_last   (s_axis_rx_data_last),
    .m_axis_app_valid      (m_axis_app_valid),
    .m_axis_app_ready      (m_axis_app_ready),
    .m_axis_app_data       (m_axis_app_data),
    .m_axis_app_keep       (m_axis_app_keep),
    .m_axis_app_last       (m_axis_app_last),
    .m_axis_app_session    (m_axis_app_session),
    .stat_notif_cnt        (stat_notif_cnt),
    .stat_req_cnt          (stat_req_cnt),
    .stat_byte_cnt         (stat_byte_cnt),
    .stat_sess_err_cnt     (stat_sess_err_cnt),
    .stat_len_err_cnt      (stat_len_err_cnt),
    .err_sticky            (err_sticky)
  );

  always #5 net_clk = ~net_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [15:0]   session;
  } beat_t;

  typedef struct {
    logic [15:0] session;
    logic [15:0] len;
  } req_t;

  // Reference model state
  beat_t exp_beats[$];
  req_t  exp_req[$];
  req_t  model_pend[$];
  int    req_cyc[$];
  int    exp_notif, exp_reqs, exp_bytes, exp_sess_err, exp_len_err;
  bit    exp_sticky;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    req_fired = 0;
  bit    bp_en = 1'b0;
  bit    held_v = 1'b0;
  logic [31:0] held_rp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge net_clk) cyc = cyc + 1;

  // Random app backpressure when enabled.
  initial forever begin
    @(posedge net_clk);
    #1;
    m_axis_app_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Request monitor: every accepted request must be the next one the model
  // derived from the notifications; stalled requests must hold their data.
  always @(negedge net_clk) begin
    req_t r;
    if (held_v && m_axis_read_pkg_valid)
      check("rp_stable", m_axis_read_pkg_data, held_rp);
    if (m_axis_read_pkg_valid && m_axis_read_pkg_ready) begin
      if (exp_req.size() == 0) begin
        check("rp_unexpected", 1, 0);
      end else begin
        r = exp_req.pop_front();
        check("rp_session", m_axis_read_pkg_data[15:0], r.session);
        check("rp_len", m_axis_read_pkg_data[31:16], r.len);
        model_pend.push_back(r);
      end
      req_fired++;
      req_cyc.push_back(cyc + 1);
    end
    held_v  = m_axis_read_pkg_valid && !m_axis_read_pkg_ready;
    held_rp = m_axis_read_pkg_data;
  end

  // App monitor: beats must arrive in order, unchanged, with the meta tag.
  always @(negedge net_clk) begin
    beat_t b;
    if (m_axis_app_valid && m_axis_app_ready) begin
      if (exp_beats.size() == 0) begin
        check("app_unexpected", 1, 0);
      end else begin
        b = exp_beats.pop_front();
        check("app_data", m_axis_app_data, b.data);
        check("app_keep", m_axis_app_keep, b.keep);
        check("app_last", m_axis_app_last, b.last);
        check("app_session", m_axis_app_session, b.session);
      end
    end
  end

  task automatic tick();
    @(posedge net_clk);
    #1;
  endtask

  task automatic send_notif(input logic [15:0] s, input int len, output int acc_cyc);
    notification_t n;
    int rem;
    int l;
    int w;
    n         = '0;
    n.session = s;
    n.length  = 16'(len);
    n.ip      = $urandom;
    n.port    = 16'($urandom);
    n.closed  = 1'($urandom);
    exp_notif++;
    rem = len;
    while (rem > 0) begin
      l = (rem > MAXR) ? MAXR : rem;
      exp_req.push_back(req_t'{session: s, len: 16'(l)});
      exp_reqs++;
      rem -= l;
    end
    tick();
    s_axis_notif_valid = 1'b1;
    s_axis_notif_data  = n;
    w = 0;
    do begin
      @(negedge net_clk);
      w++;
    end while (!s_axis_notif_ready && w < LIMIT);
    if (!s_axis_notif_ready) check("notif_timeout", 0, 1);
    acc_cyc = cyc + 1;
    tick();
    s_axis_notif_valid = 1'b0;
  endtask

  task automatic wait_req(input int target);
    int w;
    w = 0;
    while (req_fired < target && w < LIMIT) begin
      @(negedge net_clk);
      w++;
    end
    if (req_fired < target) check("req_timeout", req_fired, target);
  endtask

  // Answers the oldest outstanding read. sess_xor corrupts the meta session,
  // len_delta changes the payload size; stop_beats > 0 leaves the packet
  // unfinished with one more beat offered but not yet accepted.
  task automatic send_packet(input logic [15:0] sess_xor, input int len_delta,
                             input bit gaps, input int stop_beats);
    req_t        h;
    beat_t       b;
    logic [15:0] meta;
    int          nb;
    int          rem;
    int          w;
    int          idx;
    w = 0;
    while (model_pend.size() == 0 && w < LIMIT) begin
      @(negedge net_clk);
      w++;
    end
    if (model_pend.size() == 0) begin
      check("pend_timeout", 0, 1);
      return;
    end
    h    = model_pend.pop_front();
    meta = h.session ^ sess_xor;
    nb   = int'(h.len) + len_delta;
    if (meta != h.session) begin
      exp_sess_err++;
      exp_sticky = 1'b1;
    end
    if (nb != int'(h.len)) begin
      exp_len_err++;
      exp_sticky = 1'b1;
    end
    exp_bytes += nb;

    tick();
    s_axis_rx_meta_valid = 1'b1;
    s_axis_rx_meta_data  = meta;
    w = 0;
    do begin
      @(negedge net_clk);
      w++;
    end while (!s_axis_rx_meta_ready && w < LIMIT);
    if (!s_axis_rx_meta_ready) check("meta_timeout", 0, 1);
    tick();
    s_axis_rx_meta_valid = 1'b0;

    rem = nb;
    idx = 0;
    while (rem > 0) begin
      if (stop_beats > 0 && idx == stop_beats) begin
        s_axis_rx_data_valid = 1'b1;
        s_axis_rx_data_data  = {$urandom, $urandom};
        s_axis_rx_data_keep  = '1;
        s_axis_rx_data_last  = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) tick();
      b.data    = {$urandom, $urandom};
      b.keep    = (rem >= KW) ? '1 : KW'((1 << rem) - 1);
      b.last    = (rem <= KW);
      b.session = meta;
      exp_beats.push_back(b);
      s_axis_rx_data_valid = 1'b1;
      s_axis_rx_data_data  = b.data;
      s_axis_rx_data_keep  = b.keep;
      s_axis_rx_data_last  = b.last;
      w = 0;
      do begin
        @(negedge net_clk);
        w++;
      end while (!s_axis_rx_data_ready && w < LIMIT);
      if (!s_axis_rx_data_ready) check("beat_timeout", 0, 1);
      rem -= (rem >= KW) ? KW : rem;
      idx++;
      tick();
      s_axis_rx_data_valid = 1'b0;
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_notif_cnt"}, stat_notif_cnt, exp_notif);
    check({tag, "_req_cnt"}, stat_req_cnt, exp_reqs);
    check({tag, "_byte_cnt"}, stat_byte_cnt, exp_bytes);
    check({tag, "_sess_err"}, stat_sess_err_cnt, exp_sess_err);
    check({tag, "_len_err"}, stat_len_err_cnt, exp_len_err);
    check({tag, "_sticky"}, err_sticky, exp_sticky);
  endtask

  task automatic clear_model();
    exp_beats.delete();
    exp_req.delete();
    model_pend.delete();
    exp_notif    = 0;
    exp_reqs     = 0;
    exp_bytes    = 0;
    exp_sess_err = 0;
    exp_len_err  = 0;
    exp_sticky   = 1'b0;
  endtask

  initial begin
    int ac;
    int base;
    logic [15:0] x;
    int d;

    s_axis_notif_valid    = 1'b0;
    s_axis_notif_data     = '0;
    m_axis_read_pkg_ready = 1'b1;
    s_axis_rx_meta_valid  = 1'b0;
    s_axis_rx_meta_data   = '0;
    s_axis_rx_data_valid  = 1'b0;
    s_axis_rx_data_data   = '0;
    s_axis_rx_data_keep   = '0;
    s_axis_rx_data_last   = 1'b0;
    clear_model();

    // Reset state
    #2;
    check("rst_rp_valid", m_axis_read_pkg_valid, 0);
    check("rst_app_valid", m_axis_app_valid, 0);
    check("rst_meta_ready", s_axis_rx_meta_ready, 0);
    check_stats("rst0");
    #11 net_aresetn = 1'b1;

    // Zero-length notification: counted, no request.
    send_notif(16'h0003, 0, ac);
    repeat (5) tick();
    check("t3_no_req", req_fired, 0);
    check_stats("t3");

    // Single request, 125 full beats.
    send_notif(16'h0007, 1000, ac);
    wait_req(1);
    check("t1_latency", req_cyc[0], ac + 1);
    send_packet(16'h0, 0, 1'b0, 0);
    repeat (2) tick();
    check("t1_beats_left", exp_beats.size(), 0);
    check_stats("t1");

    // 4000 bytes -> 1536, 1536, 928 back to back.
    base = req_fired;
    send_notif(16'h0021, 4000, ac);
    wait_req(base + 3);
    check("t2_latency", req_cyc[base], ac + 1);
    check("t2_gap1", req_cyc[base+1] - req_cyc[base], 1);
    check("t2_gap2", req_cyc[base+2] - req_cyc[base+1], 1);
    repeat (3) send_packet(16'h0, 0, 1'b0, 0);
    repeat (2) tick();
    check_stats("t2");

    // Nine requests against an eight-deep FIFO.
    base = req_fired;
    send_notif(16'h0044, 9 * MAXR, ac);
    repeat (30) tick();
    check("t4_accepted", req_fired - base, 8);
    check("t4_held_low", m_axis_read_pkg_valid, 0);
    send_packet(16'h0, 0, 1'b0, 0);
    repeat (3) tick();
    check("t4_ninth", req_fired - base, 9);
    repeat (8) send_packet(16'h0, 0, 1'b1, 0);
    repeat (2) tick();
    check_stats("t4");

    // Session mismatch (0x0009 vs 0x0007), then an 8-byte short packet.
    send_notif(16'h0007, 1000, ac);
    send_packet(16'h000E, 0, 1'b0, 0);
    repeat (2) tick();
    check("t5_sess_err_one", stat_sess_err_cnt, 1);
    check("t5_sticky_set", err_sticky, 1);
    send_notif(16'h0007, 1000, ac);
    send_packet(16'h0, -8, 1'b0, 0);
    repeat (2) tick();
    check("t5_len_err_one", stat_len_err_cnt, 1);
    check_stats("t5");

    // Random sessions, lengths, occasional errors, 50% app backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_notif(16'($urandom), $urandom_range(1, MAXR), ac);
      x = ($urandom_range(0, 4) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 16)) : 0;
      send_packet(x, d, 1'b1, 0);
    end
    bp_en = 1'b0;
    repeat (3) tick();
    check("t6_drained", exp_beats.size(), 0);
    check_stats("t6");

    // Reset mid-packet with a second request stalled and a beat offered.
    m_axis_read_pkg_ready = 1'b0;
    send_notif(16'h0055, 2000, ac);
    m_axis_read_pkg_ready = 1'b1;
    tick();
    m_axis_read_pkg_ready = 1'b0;
    send_packet(16'h0, 0, 1'b0, 3);
    check("pre_rst_rp_valid", m_axis_read_pkg_valid, 1);
    check("pre_rst_app_valid", m_axis_app_valid, 1);
    #1 net_aresetn = 1'b0;
    #1;
    clear_model();
    check("mid_rst_rp_valid", m_axis_read_pkg_valid, 0);
    check("mid_rst_app_valid", m_axis_app_valid, 0);
    check("mid_rst_data_ready", s_axis_rx_data_ready, 0);
    check("mid_rst_meta_ready", s_axis_rx_meta_ready, 0);
    check_stats("mid_rst");
    s_axis_rx_data_valid  = 1'b0;
    m_axis_read_pkg_ready = 1'b1;
    repeat (2) tick();
    #2 net_aresetn = 1'b1;

    // Clean packet after reset.
    send_notif(16'h0066, 1000, ac);
    send_packet(16'h0, 0, 1'b0, 0);
    repeat (2) tick();
    check("post_beats_left", exp_beats.size(), 0);
    check_stats("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
